// File: rtl/control_unit_if.sv
// Instruction-memory fetch bus between the control unit (master) and the instruction store (slave).
interface control_unit_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;

    modport master (output imem_req, imem_addr, input imem_valid, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, decodes them and issues
// one-cycle ALU / register-file / illegal strobes.
//
//   state     | meaning
//   FETCH     | request word at pc, wait for imem_valid
//   DECODE    | register selects/immediate presented, no strobes
//   EXECUTE   | alu_en, reg_we (STOREI/DELETE), illegal, or jump/halt
//   WRITEBACK | reg_we for ALU-class results
//   HALTED    | parked until reset
module control_unit (
    input  logic                  clk,
    input  logic                  reset,
    control_unit_if.master        imem,
    output logic                  alu_en,
    output logic [3:0]            alu_op,
    output logic [1:0]            src_a,
    output logic [1:0]            src_b,
    output logic                  reg_we,
    output logic [1:0]            reg_waddr,
    output logic [1:0]            wdata_sel,
    output logic [3:0]            imm,
    output logic [7:0]            pc,
    output logic                  illegal,
    output logic                  halted
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALTED    = 3'd4
    } state_t;

    localparam logic [3:0] OP_STOREI = 4'b1000;
    localparam logic [3:0] OP_JUMP   = 4'b1001;
    localparam logic [3:0] OP_DELETE = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    state_t      state;
    logic [15:0] ir;
    logic [7:0]  pc_q;
    logic        req_q;
    logic        alu_en_q;
    logic        reg_we_q;
    logic        illegal_q;
    logic        halted_q;
    logic [3:0]  op;

    assign op = ir[15:12];

    // Strobes are registered one transition ahead so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            ir        <= 16'h0000;
            pc_q      <= 8'h00;
            req_q     <= 1'b1;
            alu_en_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_valid) begin
                        ir    <= imem.imem_data;
                        pc_q  <= pc_q + 8'd1;
                        req_q <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state     <= EXECUTE;
                    alu_en_q  <= ~op[3];
                    reg_we_q  <= (op == OP_STOREI) || (op == OP_DELETE);
                    illegal_q <= (op >= 4'b1011) && (op <= 4'b1110);
                end
                EXECUTE: begin
                    alu_en_q  <= 1'b0;
                    reg_we_q  <= 1'b0;
                    illegal_q <= 1'b0;
                    if (!op[3]) begin
                        reg_we_q <= 1'b1;
                        state    <= WRITEBACK;
                    end else if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state    <= HALTED;
                    end else begin
                        if (op == OP_JUMP) begin
                            pc_q <= ir[7:0];
                        end
                        req_q <= 1'b1;
                        state <= FETCH;
                    end
                end
                WRITEBACK: begin
                    reg_we_q <= 1'b0;
                    req_q    <= 1'b1;
                    state    <= FETCH;
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    req_q <= 1'b1;
                    state <= FETCH;
                end
            endcase
        end
    end

    // Destination and write source come straight from IR; reg_we alone qualifies them.
    always_comb begin
        wdata_sel = 2'b00;
        if (op == OP_STOREI) begin
            wdata_sel = 2'b01;
        end else if (op == OP_DELETE) begin
            wdata_sel = 2'b10;
        end
    end

    assign reg_waddr      = op[3] ? ir[11:10] : ir[7:6];
    assign alu_op         = op;
    assign src_a          = ir[11:10];
    assign src_b          = ir[9:8];
    assign imm            = ir[3:0];
    assign pc             = pc_q;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign alu_en         = alu_en_q;
    assign reg_we         = reg_we_q;
    assign illegal        = illegal_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed expectations, sampled on the falling edge.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       alu_en;
    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic [1:0] wdata_sel;
    logic [3:0] imm;
    logic [7:0] pc;
    logic       illegal;
    logic       halted;
    int         checks;
    int         errors;

    control_unit_if bus ();

    control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .imem      (bus),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .wdata_sel (wdata_sel),
        .imm       (imm),
        .pc        (pc),
        .illegal   (illegal),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Fetch one word: present it in FETCH, take the capture edge, drop valid.
    task automatic fetch(input logic [15:0] word);
        bus.imem_valid = 1'b1;
        bus.imem_data  = word;
        step();
        bus.imem_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'h0000;
        step();
        step();

        // reset state
        chk("rst_req",   16'(bus.imem_req), 16'h1);
        chk("rst_addr",  16'(bus.imem_addr), 16'h0);
        chk("rst_pc",    16'(pc), 16'h0);
        chk("rst_alu",   16'(alu_en), 16'h0);
        chk("rst_we",    16'(reg_we), 16'h0);
        chk("rst_ill",   16'(illegal), 16'h0);
        chk("rst_halt",  16'(halted), 16'h0);
        chk("rst_op",    16'(alu_op), 16'h0);
        chk("rst_srca",  16'(src_a), 16'h0);
        chk("rst_srcb",  16'(src_b), 16'h0);
        chk("rst_waddr", 16'(reg_waddr), 16'h0);
        chk("rst_wsel",  16'(wdata_sel), 16'h0);
        chk("rst_imm",   16'(imm), 16'h0);

        // STOREI 0x8A05 at pc 0
        reset = 1'b0;
        fetch(16'h8A05);
        chk("st_dec_pc",   16'(pc), 16'h1);
        chk("st_dec_req",  16'(bus.imem_req), 16'h0);
        chk("st_dec_we",   16'(reg_we), 16'h0);
        chk("st_dec_srca", 16'(src_a), 16'h2);
        chk("st_dec_srcb", 16'(src_b), 16'h2);
        step();
        chk("st_ex_we",    16'(reg_we), 16'h1);
        chk("st_ex_waddr", 16'(reg_waddr), 16'h2);
        chk("st_ex_wsel",  16'(wdata_sel), 16'h1);
        chk("st_ex_imm",   16'(imm), 16'h5);
        chk("st_ex_alu",   16'(alu_en), 16'h0);
        step();
        chk("st_f_we",     16'(reg_we), 16'h0);
        chk("st_f_req",    16'(bus.imem_req), 16'h1);
        chk("st_f_addr",   16'(bus.imem_addr), 16'h1);

        // ALU 0x31C0 at pc 1; a stray valid during DECODE must be ignored
        fetch(16'h31C0);
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'hFFFF;
        chk("alu_dec_en",  16'(alu_en), 16'h0);
        step();
        bus.imem_valid = 1'b0;
        chk("alu_ex_en",   16'(alu_en), 16'h1);
        chk("alu_ex_op",   16'(alu_op), 16'h3);
        chk("alu_ex_srca", 16'(src_a), 16'h0);
        chk("alu_ex_srcb", 16'(src_b), 16'h1);
        chk("alu_ex_we",   16'(reg_we), 16'h0);
        chk("alu_ex_pc",   16'(pc), 16'h2);
        step();
        chk("alu_wb_we",    16'(reg_we), 16'h1);
        chk("alu_wb_waddr", 16'(reg_waddr), 16'h3);
        chk("alu_wb_wsel",  16'(wdata_sel), 16'h0);
        chk("alu_wb_en",    16'(alu_en), 16'h0);
        step();
        chk("alu_f_we",    16'(reg_we), 16'h0);
        chk("alu_f_addr",  16'(bus.imem_addr), 16'h2);

        // reserved 0xC000 at pc 2
        fetch(16'hC000);
        chk("rsv_dec_ill", 16'(illegal), 16'h0);
        step();
        chk("rsv_ex_ill",  16'(illegal), 16'h1);
        chk("rsv_ex_we",   16'(reg_we), 16'h0);
        chk("rsv_ex_alu",  16'(alu_en), 16'h0);
        step();
        chk("rsv_f_ill",   16'(illegal), 16'h0);
        chk("rsv_f_req",   16'(bus.imem_req), 16'h1);
        chk("rsv_f_addr",  16'(bus.imem_addr), 16'h3);

        // FETCH stall for 10 cycles at pc 3
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_req", 16'(bus.imem_req), 16'h1);
            chk("stall_pc",  16'(pc), 16'h3);
        end

        // JUMP to 0x10, then JUMP 0x90FF, then DELETE at 0xFF wraps pc to 0
        fetch(16'h9010);
        step();
        step();
        chk("jmp1_addr", 16'(bus.imem_addr), 16'h10);
        fetch(16'h90FF);
        chk("jmp2_dec_pc", 16'(pc), 16'h11);
        step();
        chk("jmp2_ex_we",  16'(reg_we), 16'h0);
        step();
        chk("jmp2_addr",   16'(bus.imem_addr), 16'hFF);
        chk("jmp2_req",    16'(bus.imem_req), 16'h1);
        fetch(16'hA400);
        chk("wrap_pc",     16'(pc), 16'h0);
        step();
        chk("del_we",      16'(reg_we), 16'h1);
        chk("del_waddr",   16'(reg_waddr), 16'h1);
        chk("del_wsel",    16'(wdata_sel), 16'h2);
        step();
        chk("del_f_addr",  16'(bus.imem_addr), 16'h0);

        // reset asserted during WRITEBACK of ALU 0x1280
        fetch(16'h1280);
        step();
        step();
        chk("wbr_we",     16'(reg_we), 16'h1);
        chk("wbr_waddr",  16'(reg_waddr), 16'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("wbr_we0",    16'(reg_we), 16'h0);
        chk("wbr_pc",     16'(pc), 16'h0);
        chk("wbr_req",    16'(bus.imem_req), 16'h1);
        chk("wbr_op",     16'(alu_op), 16'h0);

        // reset wins over a same-edge capture
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'h8A05;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.imem_valid = 1'b0;
        chk("rsv_edge_pc",  16'(pc), 16'h0);
        chk("rsv_edge_req", 16'(bus.imem_req), 16'h1);
        chk("rsv_edge_imm", 16'(imm), 16'h0);

        // HALT 0xF000, hold 20 cycles with toggling valid, then reset
        fetch(16'hF000);
        step();
        chk("hlt_ex_halt", 16'(halted), 16'h0);
        step();
        bus.imem_data = 16'h8A05;
        for (int i = 0; i < 20; i++) begin
            bus.imem_valid = ~bus.imem_valid;
            chk("hlt_halt", 16'(halted), 16'h1);
            chk("hlt_req",  16'(bus.imem_req), 16'h0);
            chk("hlt_pc",   16'(pc), 16'h1);
            chk("hlt_we",   16'(reg_we), 16'h0);
            step();
        end
        bus.imem_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("hlt_rst_halt", 16'(halted), 16'h0);
        chk("hlt_rst_pc",   16'(pc), 16'h0);
        chk("hlt_rst_req",  16'(bus.imem_req), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
